fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU.
//  Issues PC-addressed reads to instruction memory and captures the returned word into IF/ID.
//  Obeys Stall from the hazard detector (hold IF/ID, buffer fetched word) and Flush/redirect from EX.
//  Its IF_ID_inst output is the instruction decoded and hazard-checked in ID.
// PARAMETERS
//  RESET_PC  16'h0000  PC value after reset
//  NOP_INST  16'hF01D  bubble encoding: R-type, func 29, reads/writes no register
//  CNT_W     16        width of perf counters (FETCH_PERF_CNT_EN only)
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-high
//  Stall          in   1        from hazard detector; ID must hold current instruction
//  Flush          in   1        taken branch/jump resolved in EX; kill IF and IF/ID
//  RedirectPC     in   16       new fetch address, valid with Flush
//  i_readM        out  1        instruction read request
//  i_address      out  16       address of outstanding request, stable until i_ready
//  i_data         in   16       read data, valid with i_ready
//  i_ready        in   1        one-cycle pulse completing current request (latency >=1)
//  IF_ID_inst     out  16       instruction to ID (NOP_INST when invalid)
//  IF_ID_PCplus1  out  16       fetch address + 1 of IF_ID_inst (for JRL/branches)
//  IF_ID_Valid    out  1        IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: PC=RESET_PC, i_address=RESET_PC, state=FETCH, IF_ID_Valid=0, IF_ID_inst=NOP_INST,
//   IF_ID_PCplus1=0, hold buffer empty. i_readM=0 while reset high; 1 in first cycle after release.
//  i_readM = (state!=HOLD) & ~reset. PC+1 wraps 16'hFFFF->16'h0000.
//  States (registered):
//   FETCH: request at i_address outstanding.
//    Flush & i_ready    -> FETCH; data dropped; PC=i_address=RedirectPC.
//    Flush & ~i_ready   -> DRAIN; PC=RedirectPC; i_address unchanged.
//    i_ready & ~Stall   -> FETCH; IF/ID<={i_data,i_address+1,Valid=1}; PC=i_address=i_address+1.
//    i_ready & Stall    -> HOLD; buf<={i_data,i_address+1}; PC=i_address+1; IF/ID held.
//    ~i_ready           -> FETCH.
//   HOLD: no request; word waits in buf.
//    Flush     -> FETCH; buf dropped; PC=i_address=RedirectPC.
//    ~Stall    -> FETCH; IF/ID<=buf, Valid=1; i_address=PC (next request issued next cycle).
//   DRAIN: stale request outstanding; its data must never reach IF/ID.
//    i_ready   -> FETCH; data dropped; i_address=PC (latest redirect).
//    Flush     -> PC=RedirectPC (last redirect wins); stay DRAIN unless i_ready.
//  IF/ID update, each edge, priority order:
//   Flush -> Valid=0, inst=NOP_INST (overrides Stall).
//   Stall -> hold all IF/ID outputs.
//   new word available (rule above) -> load it.
//   else -> bubble: Valid=0, inst=NOP_INST, PCplus1 held.
//  No instruction lost or duplicated: every non-flushed address reaches IF/ID exactly once, in order.
//  Reset asserted mid-request: state and outputs return to reset values immediately;
//   late i_ready after reset release in FETCH is treated as completion of RESET_PC request
//   (memory is reset with CPU).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs StallCycles, BubbleCycles, FlushCount, each [CNT_W-1:0].
//   Counted per clock edge: Stall&~Flush; IF/ID loaded with bubble; Flush.
//   Counters saturate at all-ones; reset to 0.
//  Not defined: ports and counters absent; functional behaviour identical.
// TESTING
//  1 Reset release, i_ready every cycle, Stall=Flush=0, mem[n]=n:
//    IF_ID_inst 0,1,2,... on consecutive cycles; PCplus1 = inst+1; Valid=1 from 2nd edge after release.
//  2 Stall=1 for 3 cycles while word 5 arrives: IF_ID_inst holds 4; i_readM=0 in HOLD;
//    after Stall drops, 5 then 6 appear; no skip or duplicate.
//  3 Latency 3 (i_ready every 3rd cycle): i_address stable through each wait;
//    IF_ID_Valid=0 for two of every three cycles; bubbles show NOP_INST.
//  4 Flush, RedirectPC=16'h0040, while request 7 pending: DRAIN; i_address stays 7 until i_ready.
//    Word 7 dropped; next request 0x40; first valid IF_ID_inst = mem[0x40].
//  5 Flush and Stall same cycle, state HOLD: Valid=0 next edge; buffered word discarded;
//    fetch resumes at RedirectPC.
//  6 PC=16'hFFFF fetched: IF_ID_PCplus1=0 and next request 16'h0000.
//    With FETCH_PERF_CNT_EN: StallCycles counts exactly the stall cycles of test 2 (=3).

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with IF/ID pipeline register, stall hold buffer
//            and flush/redirect handling. Optional FETCH_PERF_CNT_EN macro
//            adds saturating stall/bubble/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'hF01D
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int          CNT_W    = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [15:0] RedirectPC,
    output logic        i_readM,
    output logic [15:0] i_address,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic [15:0] IF_ID_inst,
    output logic [15:0] IF_ID_PCplus1,
    output logic        IF_ID_Valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] BubbleCycles,
    output logic [CNT_W-1:0] FlushCount
`endif
);

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic [15:0] r_buf_inst;
    logic [15:0] r_buf_pcp1;
    logic [15:0] r_inst;
    logic [15:0] r_pcp1;
    logic        r_valid;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_addr_nxt;
    logic [15:0] w_addr_inc;
    logic        w_buf_load;
    logic        w_word_load;
    logic [15:0] w_word_inst;
    logic [15:0] w_word_pcp1;

    assign w_addr_inc    = r_addr + 16'd1;
    assign i_readM       = (r_state != c_HOLD) & ~reset;
    assign i_address     = r_addr;
    assign IF_ID_inst    = r_inst;
    assign IF_ID_PCplus1 = r_pcp1;
    assign IF_ID_Valid   = r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_buf_load  = 1'b0;
        w_word_load = 1'b0;
        w_word_inst = i_data;
        w_word_pcp1 = w_addr_inc;
        case (r_state)
            c_FETCH: begin
                if (Flush) begin
                    w_pc_nxt = RedirectPC;
                    // A pending request can only be abandoned once memory answers it
                    if (i_ready) w_addr_nxt  = RedirectPC;
                    else         w_state_nxt = c_DRAIN;
                end else if (i_ready) begin
                    w_pc_nxt = w_addr_inc;
                    if (Stall) begin
                        w_state_nxt = c_HOLD;
                        w_buf_load  = 1'b1;
                    end else begin
                        w_word_load = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                    end
                end
            end
            c_HOLD: begin
                if (Flush) begin
                    w_state_nxt = c_FETCH;
                    w_pc_nxt    = RedirectPC;
                    w_addr_nxt  = RedirectPC;
                end else if (!Stall) begin
                    w_state_nxt = c_FETCH;
                    w_word_load = 1'b1;
                    w_word_inst = r_buf_inst;
                    w_word_pcp1 = r_buf_pcp1;
                    w_addr_nxt  = r_pc;
                end
            end
            c_DRAIN: begin
                if (Flush) w_pc_nxt = RedirectPC;
                if (i_ready) begin
                    w_state_nxt = c_FETCH;
                    w_addr_nxt  = Flush ? RedirectPC : r_pc;
                end
            end
            default: begin
                w_state_nxt = c_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_FETCH;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_buf_inst <= NOP_INST;
            r_buf_pcp1 <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            if (w_buf_load) begin
                r_buf_inst <= i_data;
                r_buf_pcp1 <= w_addr_inc;
            end
        end
    end

    // IF/ID: flush beats stall, stall beats new word, otherwise a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst  <= NOP_INST;
            r_pcp1  <= 16'h0000;
            r_valid <= 1'b0;
        end else if (Flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (Stall) begin
            r_inst  <= r_inst;
        end else if (w_word_load) begin
            r_inst  <= w_word_inst;
            r_pcp1  <= w_word_pcp1;
            r_valid <= 1'b1;
        end else begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_bubble;

    assign w_bubble     = Flush | (~Stall & ~w_word_load);
    assign StallCycles  = r_stall_cnt;
    assign BubbleCycles = r_bubble_cnt;
    assign FlushCount   = r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (Stall && !Flush && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (Flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed vector bench for fetch_stage; memory returns mem[n]=n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] c_NOP = 16'hF01D;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [15:0] RedirectPC;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] IF_ID_inst;
    logic [15:0] IF_ID_PCplus1;
    logic        IF_ID_Valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] StallCycles;
    logic [15:0] BubbleCycles;
    logic [15:0] FlushCount;
`endif

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .Stall         (Stall),
        .Flush         (Flush),
        .RedirectPC    (RedirectPC),
        .i_readM       (i_readM),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .IF_ID_inst    (IF_ID_inst),
        .IF_ID_PCplus1 (IF_ID_PCplus1),
        .IF_ID_Valid   (IF_ID_Valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCycles   (StallCycles),
        .BubbleCycles  (BubbleCycles),
        .FlushCount    (FlushCount)
`endif
    );

    assign i_data = i_ready ? i_address : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        rdy;
        logic [15:0] rpc;
        logic        e_v;
        logic [15:0] e_inst;
        logic [15:0] e_pcp1;
        logic [15:0] e_addr;
        logic        e_rd;
    } vec_t;

    vec_t tv[$];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic fl, input logic rdy, input logic [15:0] rpc,
                       input logic v, input logic [15:0] inst, input logic [15:0] pcp1,
                       input logic [15:0] addr, input logic rd);
        vec_t t;
        t.st = st; t.fl = fl; t.rdy = rdy; t.rpc = rpc;
        t.e_v = v; t.e_inst = inst; t.e_pcp1 = pcp1; t.e_addr = addr; t.e_rd = rd;
        tv.push_back(t);
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [15:0] inst,
                            input logic [15:0] pcp1, input logic [15:0] addr, input logic rd);
        chk({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
        chk({tag, ".inst"},  {16'd0, IF_ID_inst},  {16'd0, inst});
        chk({tag, ".pcp1"},  {16'd0, IF_ID_PCplus1}, {16'd0, pcp1});
        chk({tag, ".addr"},  {16'd0, i_address},   {16'd0, addr});
        chk({tag, ".readM"}, {31'd0, i_readM},     {31'd0, rd});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //   st fl rdy rpc       v  inst      pcp1      addr      rd
        // straight-line fetch, mem[n]=n
        add(0, 0, 1, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0001, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0001, 16'h0002, 16'h0002, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0002, 16'h0003, 16'h0003, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0003, 16'h0004, 16'h0004, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0004, 16'h0005, 16'h0005, 1);
        // three stall cycles while word 5 arrives
        add(1, 0, 1, 16'h0000, 1, 16'h0004, 16'h0005, 16'h0005, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0005, 16'h0005, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0005, 16'h0005, 0);
        add(0, 0, 0, 16'h0000, 1, 16'h0005, 16'h0006, 16'h0006, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0006, 16'h0007, 16'h0007, 1);
        // latency 3
        add(0, 0, 0, 16'h0000, 0, c_NOP,    16'h0007, 16'h0007, 1);
        add(0, 0, 0, 16'h0000, 0, c_NOP,    16'h0007, 16'h0007, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0007, 16'h0008, 16'h0008, 1);
        add(0, 0, 0, 16'h0000, 0, c_NOP,    16'h0008, 16'h0008, 1);
        add(0, 0, 0, 16'h0000, 0, c_NOP,    16'h0008, 16'h0008, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0008, 16'h0009, 16'h0009, 1);
        // flush to 0x40 with request 9 pending -> drain
        add(0, 1, 0, 16'h0040, 0, c_NOP,    16'h0009, 16'h0009, 1);
        add(0, 0, 0, 16'h0000, 0, c_NOP,    16'h0009, 16'h0009, 1);
        add(0, 0, 1, 16'h0000, 0, c_NOP,    16'h0009, 16'h0040, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0040, 16'h0041, 16'h0041, 1);
        // flush and stall together while holding
        add(1, 0, 1, 16'h0000, 1, 16'h0040, 16'h0041, 16'h0041, 0);
        add(1, 1, 0, 16'hFFFE, 0, c_NOP,    16'h0041, 16'hFFFE, 1);
        // wrap at 0xFFFF
        add(0, 0, 1, 16'h0000, 1, 16'hFFFE, 16'hFFFF, 16'hFFFF, 1);
        add(0, 0, 1, 16'h0000, 1, 16'hFFFF, 16'h0000, 16'h0000, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0001, 1);
        // repeated redirect during drain: last one wins
        add(0, 1, 0, 16'h0100, 0, c_NOP,    16'h0001, 16'h0001, 1);
        add(0, 1, 0, 16'h0200, 0, c_NOP,    16'h0001, 16'h0001, 1);
        add(0, 0, 1, 16'h0000, 0, c_NOP,    16'h0001, 16'h0200, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0200, 16'h0201, 16'h0201, 1);
        // flush coincident with completion in FETCH
        add(0, 1, 1, 16'h0300, 0, c_NOP,    16'h0201, 16'h0300, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0300, 16'h0301, 16'h0301, 1);
        // stall with no data keeps request outstanding
        add(1, 0, 0, 16'h0000, 1, 16'h0300, 16'h0301, 16'h0301, 1);
        add(0, 0, 1, 16'h0000, 1, 16'h0301, 16'h0302, 16'h0302, 1);

        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; RedirectPC = 16'h0000; i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, c_NOP, 16'h0000, 16'h0000, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("release.readM", {31'd0, i_readM}, 32'd1);

        foreach (tv[i]) begin
            @(negedge clk);
            Stall = tv[i].st; Flush = tv[i].fl; RedirectPC = tv[i].rpc; i_ready = tv[i].rdy;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), tv[i].e_v, tv[i].e_inst, tv[i].e_pcp1,
                     tv[i].e_addr, tv[i].e_rd);
`ifdef FETCH_PERF_CNT_EN
            if (i == 9) chk("stall_cnt", {16'd0, StallCycles}, 32'd3);
`endif
        end
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt", {16'd0, FlushCount}, 32'd5);
`endif

        // reset asserted with a request in flight
        @(negedge clk);
        Stall = 1'b0; Flush = 1'b0; i_ready = 1'b0;
        #2 reset = 1'b1;
        #1 chk_outs("midreset", 0, c_NOP, 16'h0000, 16'h0000, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("midreset.bubble_cnt", {16'd0, BubbleCycles}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1 chk_outs("postreset", 1, 16'h0000, 16'h0001, 16'h0001, 1);
        @(negedge clk);
        i_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
